// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round-key sequencing logic.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRIME = 3'd2,
    FWD   = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } ks_state_t;

  // Round count for a given key length in bits: 10, 12 or 14.
  function automatic int aes_nr(input int k);
    return k / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the round-key expander: primes it, optionally runs forward
// expansion for decryption, then steps one round key per cycle to the cipher.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic [K-1:0] key,
  output logic         ready,
  output logic         expReset,
  output logic [K-1:0] expKey,
  output logic         expFwdDone,
  output logic         expFreeze,
  output logic         rkValid,
  output logic [3:0]   round,
  output logic         roundFirst,
  output logic         roundLast,
  output logic         done
);

  localparam int         NR  = aes_nr(K);
  localparam logic [3:0] NR4 = 4'(NR);

  if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
    $error("aes_key_sched_ctrl: K must be 128, 192 or 256");
  end

  ks_state_t  state_r;
  ks_state_t  state_nx_s;
  logic [3:0] counter_r;
  logic [3:0] counter_nx_s;
  logic       dir_r;
  logic       dir_nx_s;
  logic       accept_s;

  // Next-state and counter logic; only state, counter and the start handshake matter.
  always_comb begin
    state_nx_s   = state_r;
    counter_nx_s = counter_r;
    accept_s     = start && ((state_r == IDLE) || (state_r == DONE));
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        state_nx_s = PRIME;
      end
      PRIME: begin
        counter_nx_s = 4'd0;
        if (dir_r) begin
          state_nx_s = FWD;
        end else begin
          state_nx_s = ROUND;
        end
      end
      FWD: begin
        if (counter_r == (NR4 - 4'd1)) begin
          state_nx_s   = ROUND;
          counter_nx_s = 4'd0;
        end else begin
          counter_nx_s = counter_r + 4'd1;
        end
      end
      ROUND: begin
        if (counter_r >= NR4) begin
          state_nx_s = DONE;
        end else begin
          counter_nx_s = counter_r + 4'd1;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        counter_nx_s = 4'd0;
      end
    endcase
    if (accept_s) begin
      dir_nx_s = decrypt;
    end else begin
      dir_nx_s = dir_r;
    end
  end

  // State, counter and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= 4'd0;
      dir_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      counter_r <= counter_nx_s;
      dir_r     <= dir_nx_s;
    end
  end

  // Key latch: captured only at an accepted request, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      expKey <= '0;
    end else if (accept_s) begin
      expKey <= key;
    end
  end

  // Outputs are decoded from the next state so they line up with state_r yet stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready      <= 1'b1;
      expReset   <= 1'b1;
      expFreeze  <= 1'b1;
      expFwdDone <= 1'b0;
      rkValid    <= 1'b0;
      round      <= 4'd0;
      roundFirst <= 1'b0;
      roundLast  <= 1'b0;
      done       <= 1'b0;
    end else begin
      ready      <= (state_nx_s == IDLE) || (state_nx_s == DONE);
      expReset   <= (state_nx_s == IDLE) || (state_nx_s == LOAD);
      expFreeze  <= (state_nx_s == IDLE) || (state_nx_s == DONE);
      expFwdDone <= (state_nx_s == ROUND) && dir_nx_s;
      rkValid    <= (state_nx_s == ROUND);
      round      <= (state_nx_s == ROUND) ? counter_nx_s : 4'd0;
      roundFirst <= (state_nx_s == ROUND) && (counter_nx_s == 4'd0);
      roundLast  <= (state_nx_s == ROUND) && (counter_nx_s == NR4);
      done       <= (state_nx_s == DONE);
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with one instance per key length.
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  logic         clk;
  logic         reset;
  logic         start;
  logic         decrypt;
  logic [255:0] key;
  int           sel;
  int           checks;
  int           errors;

  logic         start_a [3];
  logic         ready_a [3];
  logic         expReset_a [3];
  logic         expFwdDone_a [3];
  logic         expFreeze_a [3];
  logic         rkValid_a [3];
  logic [3:0]   round_a [3];
  logic         roundFirst_a [3];
  logic         roundLast_a [3];
  logic         done_a [3];
  logic [127:0] expKey128;
  logic [191:0] expKey192;
  logic [255:0] expKey256;

  logic         o_ready, o_expReset, o_expFwdDone, o_expFreeze;
  logic         o_rkValid, o_roundFirst, o_roundLast, o_done;
  logic [3:0]   o_round;
  logic [255:0] o_expKey;

  localparam logic [255:0] KEY_A = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] KEY_B =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY_D = 256'h000102030405060708090a0b0c0d0e0f;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) start_a[i] = start && (sel == i);
  end

  aes_key_sched_ctrl #(.K(128)) u_k128 (
    .clk(clk), .reset(reset), .start(start_a[0]), .decrypt(decrypt), .key(key[127:0]),
    .ready(ready_a[0]), .expReset(expReset_a[0]), .expKey(expKey128),
    .expFwdDone(expFwdDone_a[0]), .expFreeze(expFreeze_a[0]), .rkValid(rkValid_a[0]),
    .round(round_a[0]), .roundFirst(roundFirst_a[0]), .roundLast(roundLast_a[0]),
    .done(done_a[0])
  );

  aes_key_sched_ctrl #(.K(192)) u_k192 (
    .clk(clk), .reset(reset), .start(start_a[1]), .decrypt(decrypt), .key(key[191:0]),
    .ready(ready_a[1]), .expReset(expReset_a[1]), .expKey(expKey192),
    .expFwdDone(expFwdDone_a[1]), .expFreeze(expFreeze_a[1]), .rkValid(rkValid_a[1]),
    .round(round_a[1]), .roundFirst(roundFirst_a[1]), .roundLast(roundLast_a[1]),
    .done(done_a[1])
  );

  aes_key_sched_ctrl #(.K(256)) u_k256 (
    .clk(clk), .reset(reset), .start(start_a[2]), .decrypt(decrypt), .key(key),
    .ready(ready_a[2]), .expReset(expReset_a[2]), .expKey(expKey256),
    .expFwdDone(expFwdDone_a[2]), .expFreeze(expFreeze_a[2]), .rkValid(rkValid_a[2]),
    .round(round_a[2]), .roundFirst(roundFirst_a[2]), .roundLast(roundLast_a[2]),
    .done(done_a[2])
  );

  // Observe the instance currently under test.
  always_comb begin
    o_ready      = ready_a[sel];
    o_expReset   = expReset_a[sel];
    o_expFwdDone = expFwdDone_a[sel];
    o_expFreeze  = expFreeze_a[sel];
    o_rkValid    = rkValid_a[sel];
    o_round      = round_a[sel];
    o_roundFirst = roundFirst_a[sel];
    o_roundLast  = roundLast_a[sel];
    o_done       = done_a[sel];
    case (sel)
      0:       o_expKey = {128'd0, expKey128};
      1:       o_expKey = {64'd0, expKey192};
      default: o_expKey = expKey256;
    endcase
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mask_key(input int s, input logic [255:0] k);
    logic [255:0] m;
    case (s)
      0:       m = {128'd0, {128{1'b1}}};
      1:       m = {64'd0, {192{1'b1}}};
      default: m = {256{1'b1}};
    endcase
    return k & m;
  endfunction

  // One full request with start pulsed for the accept edge only.
  task automatic run_op(input int s, input bit dec, input logic [255:0] k, input int nr,
                        input string name);
    int  done_c;
    int  first_c;
    bit  in_round;
    done_c  = dec ? 4 + 2 * nr : 4 + nr;
    first_c = dec ? 3 + nr : 3;
    @(negedge clk);
    sel = s; start = 1'b1; decrypt = dec; key = k;
    @(posedge clk);
    #1;
    start = 1'b0; decrypt = 1'b0; key = '0;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      in_round = (c >= first_c) && (c <= first_c + nr);
      check($sformatf("%s c%0d rkValid", name, c), 256'(o_rkValid), 256'(in_round));
      if (in_round)
        check($sformatf("%s c%0d round", name, c), 256'(o_round), 256'(c - first_c));
      check($sformatf("%s c%0d roundFirst", name, c), 256'(o_roundFirst), 256'(c == first_c));
      check($sformatf("%s c%0d roundLast", name, c), 256'(o_roundLast), 256'(c == first_c + nr));
      check($sformatf("%s c%0d done", name, c), 256'(o_done), 256'(c == done_c));
      check($sformatf("%s c%0d ready", name, c), 256'(o_ready), 256'(c >= done_c));
      check($sformatf("%s c%0d expReset", name, c), 256'(o_expReset), 256'(c == 1 || c > done_c));
      check($sformatf("%s c%0d expFreeze", name, c), 256'(o_expFreeze), 256'(c >= done_c));
      check($sformatf("%s c%0d expFwdDone", name, c), 256'(o_expFwdDone), 256'(in_round && dec));
      check($sformatf("%s c%0d expKey", name, c), o_expKey, mask_key(s, k));
    end
  endtask

  initial begin
    int  seen;
    checks = 0; errors = 0;
    sel = 0; start = 1'b0; decrypt = 1'b0; key = '0; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset%0d ready", s), 256'(o_ready), 256'(1));
      check($sformatf("reset%0d expReset", s), 256'(o_expReset), 256'(1));
      check($sformatf("reset%0d expFreeze", s), 256'(o_expFreeze), 256'(1));
      check($sformatf("reset%0d rkValid", s), 256'(o_rkValid), 256'(0));
      check($sformatf("reset%0d done", s), 256'(o_done), 256'(0));
      check($sformatf("reset%0d expKey", s), o_expKey, 256'(0));
    end
    reset = 1'b0;

    run_op(0, 1'b0, KEY_A, 10, "t1_enc128");
    run_op(0, 1'b1, KEY_A, 10, "t2_dec128");
    run_op(2, 1'b0, KEY_B, 14, "t3_enc256");
    run_op(2, 1'b1, KEY_B, 14, "t3_dec256");
    run_op(1, 1'b0, KEY_C, 12, "t6_enc192");

    // start held through a busy run, key and direction disturbed mid-run
    @(negedge clk);
    sel = 0; start = 1'b1; decrypt = 1'b0; key = KEY_A;
    @(posedge clk);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 13) check($sformatf("t4 c%0d ready", c), 256'(o_ready), 256'(0));
      if (c >= 3 && c <= 13) begin
        check($sformatf("t4 c%0d rkValid", c), 256'(o_rkValid), 256'(1));
        check($sformatf("t4 c%0d expFwdDone", c), 256'(o_expFwdDone), 256'(0));
        check($sformatf("t4 c%0d expKey", c), o_expKey, mask_key(0, KEY_A));
      end
      if (c == 14) check("t4 c14 done", 256'(o_done), 256'(1));
      if (c == 15) begin
        check("t4 c15 expKey", o_expKey, mask_key(0, KEY_D));
        check("t4 c15 expReset", 256'(o_expReset), 256'(1));
      end
      if (c == 16) check("t4 c16 rkValid", 256'(o_rkValid), 256'(0));
      if (c == 17) begin
        check("t4 c17 rkValid", 256'(o_rkValid), 256'(1));
        check("t4 c17 roundFirst", 256'(o_roundFirst), 256'(1));
        check("t4 c17 round", 256'(o_round), 256'(0));
      end
      if (c == 5) begin key = KEY_D; decrypt = 1'b1; end
      if (c == 12) decrypt = 1'b0;
    end
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    check("t4 second done seen", 256'(seen), 256'(1));
    @(negedge clk);

    // reset during ROUND at round 5
    @(negedge clk);
    sel = 0; start = 1'b1; decrypt = 1'b0; key = KEY_A;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    check("t5 pre round", 256'(o_round), 256'(5));
    check("t5 pre rkValid", 256'(o_rkValid), 256'(1));
    reset = 1'b1;
    @(negedge clk);
    check("t5 ready", 256'(o_ready), 256'(1));
    check("t5 expReset", 256'(o_expReset), 256'(1));
    check("t5 rkValid", 256'(o_rkValid), 256'(0));
    check("t5 done", 256'(o_done), 256'(0));
    check("t5 expKey", o_expKey, 256'(0));
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("t5 idle c%0d done", c), 256'(o_done), 256'(0));
      check($sformatf("t5 idle c%0d ready", c), 256'(o_ready), 256'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
